// File: rtl/bcd_adder.sv
// Single-digit registered BCD adder: binary add of two digits plus carry-in,
// decimal correction, one register stage. Optional invalid-digit flag under BCD_ERR_EN.
module bcd_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic Cin,
    output logic S1,
    output logic S2,
    output logic S4,
    output logic S8,
    output logic Cout
`ifdef BCD_ERR_EN
    ,
    output logic Err
`endif
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;
    logic [4:0] bin_sum;
    logic       correct;
    logic [3:0] sum_next;
    logic [3:0] sum_reg;
    logic       cout_reg;

    assign a_vec = {A3, A2, A1, A0};
    assign b_vec = {B3, B2, B1, B0};

    assign bin_sum = {1'b0, a_vec} + {1'b0, b_vec} + {4'b0000, Cin};

    // Sum of 10 or more: add 6 to wrap the low nibble past the unused codes.
    assign correct  = bin_sum[4] | (bin_sum[3] & (bin_sum[2] | bin_sum[1]));
    assign sum_next = correct ? (bin_sum[3:0] + 4'd6) : bin_sum[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= 4'd0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= sum_next;
            cout_reg <= correct;
        end
    end

    assign S1   = sum_reg[0];
    assign S2   = sum_reg[1];
    assign S4   = sum_reg[2];
    assign S8   = sum_reg[3];
    assign Cout = cout_reg;

`ifdef BCD_ERR_EN
    logic err_next;
    logic err_reg;

    assign err_next = (a_vec > 4'd9) | (b_vec > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign Err = err_reg;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: directed steps with a scoreboard queue of
// expected results, checked one cycle after each operand set is applied.
module tb_bcd_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       s1, s2, s4, s8, cout;
`ifdef BCD_ERR_EN
    logic       err;
`else
    logic       err;
    assign err = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       e;
        int         dec;
        bit         valid;
        string      tag;
    } exp_t;

    exp_t sb[$];

    bcd_adder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A0   (a[0]),
        .A1   (a[1]),
        .A2   (a[2]),
        .A3   (a[3]),
        .B0   (b[0]),
        .B1   (b[1]),
        .B2   (b[2]),
        .B3   (b[3]),
        .Cin  (cin),
        .S1   (s1),
        .S2   (s2),
        .S4   (s4),
        .S8   (s8),
        .Cout (cout)
`ifdef BCD_ERR_EN
        ,
        .Err  (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] observed();
        return {err, cout, s8, s4, s2, s1};
    endfunction

    // Direct check, used for reset values that do not come through the queue.
    task automatic check_zero(input string tag);
        compared++;
        assert (observed() === 6'd0)
        else begin
            mismatched++;
            $error("FAIL %s: observed %b required %b", tag, observed(), 6'd0);
        end
    endtask

    // Drive one operand set, push its expectation, then pop and compare after the edge.
    task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                        input string tag);
        exp_t e;
        int   total;
        a   = av;
        b   = bv;
        cin = cv;
        total   = int'(av) + int'(bv) + int'(cv);
        e.c     = (total >= 10);
        e.s     = e.c ? 4'((total + 6) % 16) : 4'(total);
        e.valid = (av <= 4'd9) && (bv <= 4'd9);
`ifdef BCD_ERR_EN
        e.e     = !e.valid;
`else
        e.e     = 1'b0;
`endif
        e.dec   = total;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compared++;
        assert (observed() === {e.e, e.c, e.s})
        else begin
            mismatched++;
            $error("FAIL %s: A=%0d B=%0d Cin=%0d observed {err,cout,s}=%b required %b",
                   e.tag, av, bv, cv, observed(), {e.e, e.c, e.s});
        end
        if (e.valid) begin
            compared++;
            assert (int'(cout) * 10 + int'({s8, s4, s2, s1}) === e.dec)
            else begin
                mismatched++;
                $error("FAIL %s_dec: observed %0d required %0d", e.tag,
                       int'(cout) * 10 + int'({s8, s4, s2, s1}), e.dec);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a = 4'd9; b = 4'd9; cin = 1'b1;
        #2;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd9, 4'd9, 1'b1, "reset_release");

        step(4'd3, 4'd4, 1'b0, "no_corr_3p4");
        step(4'd0, 4'd0, 1'b0, "zero");
        step(4'd5, 4'd4, 1'b0, "bound_9");
        step(4'd5, 4'd4, 1'b1, "bound_10");
        step(4'd8, 4'd7, 1'b0, "corr_15");

        for (int ai = 0; ai < 10; ai++)
            for (int bi = 0; bi < 10; bi++)
                for (int ci = 0; ci < 2; ci++)
                    step(4'(ai), 4'(bi), 1'(ci), "exhaustive");

        step(4'd15, 4'd15, 1'b1, "invalid_31");
        step(4'd12, 4'd0, 1'b0, "invalid_12");
        step(4'd9, 4'd9, 1'b0, "valid_after_invalid");

        // Mid-stream asynchronous reset, between clock edges while S shows 7.
        step(4'd3, 4'd4, 1'b0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_midstream");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd6, 4'd7, 1'b0, "post_async");

        compared++;
        assert (sb.size() === 0)
        else begin
            mismatched++;
            $error("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
